// File: rtl/csr_regfile_if.sv
// rtl/csr_regfile_if.sv - CSR ALU to CSR register file bus
//
// Purpose: groups every non-clock signal between the CSR ALU operation unit
// (master) and the machine-mode CSR register file (slave).
// Signals:
//   CSR_Read_Addr/CSR_Read_Data/CSR_Read_Illegal  combinational read port
//   CSR_Write_Addr/CSR_Write_Data/Write_En         generic write port
//   mcause_*/mepc_*/mtvec_*                        dedicated trap write/read ports
//   trap_valid/mret_valid                          mstatus side-effect strobes
//   instr_retire                                   minstret increment strobe
interface csr_regfile_if #(
  parameter int XLEN = 64
);
  logic [11:0]     CSR_Read_Addr;
  logic [XLEN-1:0] CSR_Read_Data;
  logic            CSR_Read_Illegal;
  logic [11:0]     CSR_Write_Addr;
  logic [XLEN-1:0] CSR_Write_Data;
  logic            Write_En;
  logic [XLEN-1:0] mcause_Write_Data;
  logic            mcause_En;
  logic [XLEN-1:0] mepc_Write_Data;
  logic            mepc_En;
  logic [XLEN-1:0] mtvec_Write_Data;
  logic            mtvec_En;
  logic [XLEN-1:0] mcause_Read_Data;
  logic [XLEN-1:0] mepc_Read_Data;
  logic [XLEN-1:0] mtvec_Read_Data;
  logic            trap_valid;
  logic            mret_valid;
  logic            instr_retire;

  modport master (
    output CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
           mcause_Write_Data, mcause_En, mepc_Write_Data, mepc_En,
           mtvec_Write_Data, mtvec_En, trap_valid, mret_valid, instr_retire,
    input  CSR_Read_Data, CSR_Read_Illegal, mcause_Read_Data, mepc_Read_Data,
           mtvec_Read_Data
  );

  modport slave (
    input  CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
           mcause_Write_Data, mcause_En, mepc_Write_Data, mepc_En,
           mtvec_Write_Data, mtvec_En, trap_valid, mret_valid, instr_retire,
    output CSR_Read_Data, CSR_Read_Illegal, mcause_Read_Data, mepc_Read_Data,
           mtvec_Read_Data
  );
endinterface

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR storage for the RV64 core
//
// Purpose: holds mstatus, mtvec, mscratch, mepc, mcause, mcycle and minstret.
// Reads are combinational from current state; writes, trap/mret side effects
// and counter updates commit on the rising clock edge.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    csr_regfile_if slave modport (read port, generic write port,
//          dedicated mcause/mepc/mtvec ports, trap/mret/retire strobes)
module csr_regfile #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000A_0000_1800,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  csr_regfile_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  // Low two bits of mepc/mtvec are hardwired zero (aligned PC, direct mode).
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  // Only MIE and MPIE are stored; every other mstatus bit is constant.
  logic            mie_q, mpie_q;
  logic            mie_d, mpie_d;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] read_data;
  logic            read_illegal;

  logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_minstret;

  assign wr_mstatus  = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MSTATUS);
  assign wr_mtvec    = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MTVEC);
  assign wr_mscratch = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MSCRATCH);
  assign wr_mepc     = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MEPC);
  assign wr_mcause   = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MCAUSE);
  assign wr_mcycle   = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MCYCLE);
  assign wr_minstret = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MINSTRET);

  always_comb begin
    mstatus_val        = MSTATUS_RST;
    mstatus_val[3]     = mie_q;
    mstatus_val[7]     = mpie_q;
    mstatus_val[12:11] = 2'b11;
  end

  // Write data lands first; trap (over mret) then overrides MIE/MPIE.
  always_comb begin
    mie_d  = mie_q;
    mpie_d = mpie_q;
    if (wr_mstatus) begin
      mie_d  = bus.CSR_Write_Data[3];
      mpie_d = bus.CSR_Write_Data[7];
    end
    if (bus.trap_valid) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (bus.mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= MSTATUS_RST[3];
      mpie_q     <= MSTATUS_RST[7];
      mtvec_q    <= MTVEC_RST & ALIGN_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q  <= mie_d;
      mpie_q <= mpie_d;

      // Dedicated ports take precedence over a same-cycle generic write.
      if (bus.mtvec_En)
        mtvec_q <= bus.mtvec_Write_Data & ALIGN_MASK;
      else if (wr_mtvec)
        mtvec_q <= bus.CSR_Write_Data & ALIGN_MASK;

      if (bus.mepc_En)
        mepc_q <= bus.mepc_Write_Data & ALIGN_MASK;
      else if (wr_mepc)
        mepc_q <= bus.CSR_Write_Data & ALIGN_MASK;

      if (bus.mcause_En)
        mcause_q <= bus.mcause_Write_Data;
      else if (wr_mcause)
        mcause_q <= bus.CSR_Write_Data;

      if (wr_mscratch)
        mscratch_q <= bus.CSR_Write_Data;

      if (wr_mcycle)
        mcycle_q <= bus.CSR_Write_Data;
      else
        mcycle_q <= mcycle_q + 1'b1;

      if (wr_minstret)
        minstret_q <= bus.CSR_Write_Data;
      else if (bus.instr_retire)
        minstret_q <= minstret_q + 1'b1;
    end
  end

  always_comb begin
    read_data    = '0;
    read_illegal = 1'b0;
    case (bus.CSR_Read_Addr)
      ADDR_MSTATUS:  read_data = mstatus_val;
      ADDR_MTVEC:    read_data = mtvec_q;
      ADDR_MSCRATCH: read_data = mscratch_q;
      ADDR_MEPC:     read_data = mepc_q;
      ADDR_MCAUSE:   read_data = mcause_q;
      ADDR_MCYCLE:   read_data = mcycle_q;
      ADDR_MINSTRET: read_data = minstret_q;
      default:       read_illegal = 1'b1;
    endcase
  end

  assign bus.CSR_Read_Data    = read_data;
  assign bus.CSR_Read_Illegal = read_illegal;
  assign bus.mcause_Read_Data = mcause_q;
  assign bus.mepc_Read_Data   = mepc_q;
  assign bus.mtvec_Read_Data  = mtvec_q;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - self-checking bench for csr_regfile
module tb_csr_regfile;

  localparam logic [63:0] MST_RST = 64'h0000_000A_0000_1800;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  csr_regfile_if #(.XLEN(64)) bus ();

  csr_regfile #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: one plain variable per architectural CSR.
  logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  function automatic logic [63:0] next_mstatus(input logic [63:0] old,
                                               input logic wr,
                                               input logic [63:0] wd,
                                               input logic trap,
                                               input logic mret);
    logic [63:0] v;
    v = old;
    if (wr) v = (MST_RST & ~64'h88) | (wd & 64'h88);
    v[12:11] = 2'b11;
    if (trap) begin
      v[7] = old[3];
      v[3] = 1'b0;
    end else if (mret) begin
      v[3] = old[7];
      v[7] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic hit(input logic [11:0] a);
    return bus.Write_En && (bus.CSR_Write_Addr == a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mstatus  <= MST_RST;
      m_mtvec    <= 64'h0;
      m_mscratch <= 64'h0;
      m_mepc     <= 64'h0;
      m_mcause   <= 64'h0;
      m_mcycle   <= 64'h0;
      m_minstret <= 64'h0;
    end else begin
      m_mstatus <= next_mstatus(m_mstatus, hit(12'h300), bus.CSR_Write_Data,
                                bus.trap_valid, bus.mret_valid);
      m_mtvec   <= (bus.mtvec_En ? bus.mtvec_Write_Data :
                    hit(12'h305) ? bus.CSR_Write_Data : m_mtvec) & ~64'h3;
      m_mepc    <= (bus.mepc_En ? bus.mepc_Write_Data :
                    hit(12'h341) ? bus.CSR_Write_Data : m_mepc) & ~64'h3;
      m_mcause  <= bus.mcause_En ? bus.mcause_Write_Data :
                   hit(12'h342) ? bus.CSR_Write_Data : m_mcause;
      m_mscratch <= hit(12'h340) ? bus.CSR_Write_Data : m_mscratch;
      m_mcycle   <= hit(12'hB00) ? bus.CSR_Write_Data : m_mcycle + 64'd1;
      m_minstret <= hit(12'hB02) ? bus.CSR_Write_Data :
                    m_minstret + (bus.instr_retire ? 64'd1 : 64'd0);
    end
  end

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [11:0] a);
    return !(a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                       12'hB00, 12'hB02});
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_data", bus.CSR_Read_Data, model_read(bus.CSR_Read_Addr));
      check("rd_illegal", {63'h0, bus.CSR_Read_Illegal},
            {63'h0, model_illegal(bus.CSR_Read_Addr)});
      check("mcause_out", bus.mcause_Read_Data, m_mcause);
      check("mepc_out", bus.mepc_Read_Data, m_mepc);
      check("mtvec_out", bus.mtvec_Read_Data, m_mtvec);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] d);
    bus.CSR_Read_Addr = a;
    #1;
    d = bus.CSR_Read_Data;
  endtask

  task automatic clear_inputs();
    bus.CSR_Write_Addr    = 12'h0;
    bus.CSR_Write_Data    = 64'h0;
    bus.Write_En          = 1'b0;
    bus.mcause_Write_Data = 64'h0;
    bus.mcause_En         = 1'b0;
    bus.mepc_Write_Data   = 64'h0;
    bus.mepc_En           = 1'b0;
    bus.mtvec_Write_Data  = 64'h0;
    bus.mtvec_En          = 1'b0;
    bus.trap_valid        = 1'b0;
    bus.mret_valid        = 1'b0;
    bus.instr_retire      = 1'b0;
  endtask

  task automatic gen_write(input logic [11:0] a, input logic [63:0] d);
    bus.Write_En       = 1'b1;
    bus.CSR_Write_Addr = a;
    bus.CSR_Write_Data = d;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h340;
      3: return 12'h341;
      4: return 12'h342;
      5: return 12'hB00;
      6: return 12'hB02;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    if ($urandom_range(0, 15) == 0)
      return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    return {$urandom, $urandom};
  endfunction

  task automatic randomize_inputs();
    bus.CSR_Read_Addr     = pick_addr();
    bus.CSR_Write_Addr    = pick_addr();
    bus.CSR_Write_Data    = rand64();
    bus.Write_En          = ($urandom_range(0, 2) == 0);
    bus.mcause_Write_Data = rand64();
    bus.mcause_En         = ($urandom_range(0, 5) == 0);
    bus.mepc_Write_Data   = rand64();
    bus.mepc_En           = ($urandom_range(0, 5) == 0);
    bus.mtvec_Write_Data  = rand64();
    bus.mtvec_En          = ($urandom_range(0, 5) == 0);
    bus.trap_valid        = ($urandom_range(0, 6) == 0);
    bus.mret_valid        = ($urandom_range(0, 6) == 0);
    bus.instr_retire      = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  pat;
    rst_n = 1'b0;
    clear_inputs();
    bus.CSR_Read_Addr = 12'h300;

    // Reset values while reset is held.
    rd(12'h300, d); check("rst_mstatus", d, 64'h0000_000A_0000_1800);
    rd(12'h305, d); check("rst_mtvec", d, 64'h0);
    rd(12'h340, d); check("rst_mscratch", d, 64'h0);
    rd(12'h341, d); check("rst_mepc", d, 64'h0);
    rd(12'h342, d); check("rst_mcause", d, 64'h0);
    rd(12'hB02, d); check("rst_minstret", d, 64'h0);
    rd(12'h7C0, d); check("rst_unimpl_data", d, 64'h0);
    check("rst_unimpl_illegal", {63'h0, bus.CSR_Read_Illegal}, 64'h1);
    rd(12'hB00, d); check("rst_mcycle", d, 64'h0);

    #3;
    rst_n = 1'b1;
    #1;
    rd(12'hB00, d); check("mcycle_0", d, 64'd0);
    cyc(); rd(12'hB00, d); check("mcycle_1", d, 64'd1);
    cyc(); rd(12'hB00, d); check("mcycle_2", d, 64'd2);

    gen_write(12'h305, 64'h8000_0103);
    cyc(); clear_inputs();
    check("mtvec_warl", bus.mtvec_Read_Data, 64'h8000_0100);

    gen_write(12'h341, 64'h8000_0007);
    cyc(); clear_inputs();
    check("mepc_warl", bus.mepc_Read_Data, 64'h8000_0004);

    gen_write(12'h300, 64'h8);
    cyc(); clear_inputs();
    rd(12'h300, d); check("mstatus_mie", d, 64'h0000_000A_0000_1808);

    bus.trap_valid        = 1'b1;
    bus.mcause_En         = 1'b1;
    bus.mcause_Write_Data = 64'd11;
    bus.mepc_En           = 1'b1;
    bus.mepc_Write_Data   = 64'h8000_0010;
    cyc(); clear_inputs();
    rd(12'h300, d); check("trap_mstatus", d, 64'h0000_000A_0000_1880);
    check("trap_mcause", bus.mcause_Read_Data, 64'd11);
    check("trap_mepc", bus.mepc_Read_Data, 64'h8000_0010);

    bus.mret_valid = 1'b1;
    cyc(); clear_inputs();
    rd(12'h300, d); check("mret_mstatus", d, 64'h0000_000A_0000_1888);

    gen_write(12'h342, 64'd7);
    cyc(); clear_inputs();
    check("mcause_generic", bus.mcause_Read_Data, 64'd7);

    gen_write(12'h342, 64'd5);
    bus.mcause_En         = 1'b1;
    bus.mcause_Write_Data = 64'd11;
    cyc(); clear_inputs();
    check("mcause_dedicated_wins", bus.mcause_Read_Data, 64'd11);

    gen_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(); clear_inputs();
    rd(12'hB00, d); check("mcycle_fe", d, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(); rd(12'hB00, d); check("mcycle_ff", d, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(); rd(12'hB00, d); check("mcycle_wrap", d, 64'h0);

    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      bus.instr_retire = pat[i];
      cyc();
    end
    clear_inputs();
    rd(12'hB02, d); check("minstret_3", d, 64'd3);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      cyc();
    end
    clear_inputs();
    bus.CSR_Read_Addr = 12'hB00;
    cyc();

    // Asynchronous reset between edges with counters running.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_mcause", bus.mcause_Read_Data, 64'h0);
    check("async_mepc", bus.mepc_Read_Data, 64'h0);
    check("async_mtvec", bus.mtvec_Read_Data, 64'h0);
    rd(12'h300, d); check("async_mstatus", d, 64'h0000_000A_0000_1800);
    rd(12'hB00, d); check("async_mcycle", d, 64'h0);
    rd(12'hB02, d); check("async_minstret", d, 64'h0);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cyc();
      randomize_inputs();
    end
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
